// File: rtl/comparador_serial_n.sv
// Sequential MSB-first magnitude comparator: one FATIA-bit slice per clock,
// unsigned or two's-complement, stopping at the first differing slice.
module comparador_serial_n #(
  parameter int WIDTH = 16,
  parameter int FATIA = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             com_sinal,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             pronto,
  output logic             fim,
  output logic             igual,
  output logic             maior,
  output logic             menor
);

  localparam int N  = WIDTH / FATIA;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] TOP = IW'(N - 1);

  typedef enum logic [1:0] {INICIAL, COMPARA, FIM} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, msb_flip;
  logic [IW-1:0]    idx;
  logic [FATIA-1:0] a_sl, b_sl;

  // Flipping the sign bit maps two's complement onto unsigned order.
  always_comb begin
    msb_flip = '0;
    msb_flip[WIDTH-1] = com_sinal;
  end

  always_comb begin
    a_sl = a_reg[int'(idx)*FATIA +: FATIA];
    b_sl = b_reg[int'(idx)*FATIA +: FATIA];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INICIAL: if (iniciar) next_state = COMPARA;
      COMPARA: if (a_sl != b_sl || idx == '0) next_state = FIM;
      FIM:     next_state = INICIAL;
      default: next_state = INICIAL;
    endcase
  end

  always_comb begin
    pronto = (state == INICIAL);
    fim    = (state == FIM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
      igual <= 1'b0;
      maior <= 1'b0;
      menor <= 1'b0;
    end else begin
      case (state)
        INICIAL: begin
          if (iniciar) begin
            a_reg <= A ^ msb_flip;
            b_reg <= B ^ msb_flip;
            idx   <= TOP;
            igual <= 1'b0;
            maior <= 1'b0;
            menor <= 1'b0;
          end
        end
        COMPARA: begin
          if (a_sl > b_sl)      maior <= 1'b1;
          else if (a_sl < b_sl) menor <= 1'b1;
          else if (idx == '0)   igual <= 1'b1;
          else                  idx   <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/comparador_serial_n.md
Name: comparador_serial_n

Overview:
- Parametrised sequential magnitude comparator. Compares two WIDTH-bit operands MSB-first, one FATIA-bit slice per clock.
- Supports unsigned and two's-complement modes.
- Terminates early on the first differing slice.
- Start/done handshake for use by FSM-controlled datapaths that cannot afford a full-width combinational compare.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of FATIA.
- FATIA, 4, slice width compared per cycle; 1 <= FATIA <= WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- iniciar  input  1  start request; sampled only when pronto=1.
- com_sinal  input  1  1 = signed (two's complement) compare, 0 = unsigned; latched with iniciar.
- A  input  WIDTH  operand A; latched with iniciar.
- B  input  WIDTH  operand B; latched with iniciar.
- pronto  output  1  idle, ready to accept iniciar.
- fim  output  1  one-cycle pulse: result valid.
- igual  output  1  A == B (registered, held).
- maior  output  1  A > B (registered, held).
- menor  output  1  A < B (registered, held).

Behaviour:
- N = WIDTH/FATIA slices. Slice k is bits [k*FATIA+FATIA-1 : k*FATIA]. The slice index counter is sized for N-1.
- FSM states: INICIAL, COMPARA, FIM.
- pronto = (state == INICIAL). fim = (state == FIM).
- Reset (reset=0, asynchronous):
  - state = INICIAL.
  - igual = maior = menor = 0, fim = 0, pronto = 1.
  - Internal operand registers and index = 0.
  - Reset mid-operation aborts the compare; no fim is produced.
- INICIAL:
  - If iniciar=1 at edge E0: latch A, B, com_sinal; index = N-1; clear igual/maior/menor to 0; go to COMPARA.
  - If iniciar=0: stay in INICIAL; results are held.
- Signed mode: invert bit WIDTH-1 of both latched operands, then compare unsigned. Only the top slice is affected.
- COMPARA, at each edge:
  - Compare slice[index] of A and B, unsigned.
  - If A slice > B slice: maior = 1, go to FIM.
  - If A slice < B slice: menor = 1, go to FIM.
  - If equal and index == 0: igual = 1, go to FIM.
  - If equal and index > 0: index = index - 1, stay in COMPARA.
- FIM: lasts exactly one cycle, then unconditionally returns to INICIAL.
- Latency:
  - Deciding slice j (counted from MSB, j = 1..N) is evaluated at edge E0+j.
  - fim is high in the cycle after E0+j.
  - pronto returns after E0+j+1.
  - Minimum 2 cycles from start to pronto; maximum N+1.
- Results:
  - Exactly one of igual/maior/menor is 1 from the fim cycle onward.
  - Results are held until the next accepted iniciar clears them.
  - All three are 0 while busy.
- iniciar while pronto=0 is ignored (not queued). Changes on A/B/com_sinal after E0 do not affect the result.
- iniciar is sampled in the INICIAL cycle immediately after FIM, so back-to-back operations are possible with one idle cycle.
- WIDTH == FATIA: single-cycle compare; fim is high in the cycle after E0+1.

Test Plan:
- Unsigned, WIDTH=16, FATIA=4, A=B=16'hA5A5, iniciar at E0 -> fim high after E0+4 only; igual=1, maior=menor=0; pronto=1 after E0+5.
- Unsigned, A=16'h8000, B=16'h7FFF -> early termination: fim after E0+1, maior=1; outputs held 10 idle cycles.
- Signed, same operands (-32768 vs 32767) -> menor=1 after E0+1. Signed A=16'hFFFF, B=16'hFFFE -> maior=1 after E0+4.
- A=16'h1234, B=16'h1235, iniciar re-pulsed and A/B changed at E0+2 -> menor=1 at the original schedule; no second fim; outputs 0 during E0+1..E0+4.
- reset=0 asserted asynchronously mid-cycle at E0+2 of an equal compare -> immediate pronto=1, all results 0, no fim.
- Then a new iniciar with A=16'h0001, B=16'h0000 -> maior=1 after E0'+4.
- Parameter sweep: WIDTH=8, FATIA=8 and WIDTH=8, FATIA=1 with random A/B/com_sinal (1000 vectors each) -> results match a reference model; latency = index of the first differing slice + 1.
